// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, NR+1 cycles per 128-bit block.
// A single round datapath is shared by every round. The round key is read combinationally
// from external key-schedule storage at index rk_idx.
module aes_inv_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NrIdx  = 4'(NR);
  localparam logic [3:0] NrLast = 4'(NR - 1);

  // Inverse S-box; entry b sits at bits [8*(255-b) +: 8].
  localparam logic [2047:0] InvSboxTbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic         accept;
  logic [127:0] shifted, subbed, keyed, mixed;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] b);
    return InvSboxTbl[{~b, 3'b000} +: 8];
  endfunction

  // Byte i of the block is bits [127-8i -: 8]; byte i is row i%4, column i/4.
  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8 * i +: 8] = invSbox(s[8 * i +: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] addRoundKey(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [127:0] invMixCollumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4], mb [4], md [4], me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127 - 8 * (4 * c + r) -: 8];
        x2    = xtime(a[r]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127 - 32 * c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                               m9[0] ^ me[1] ^ mb[2] ^ md[3],
                               md[0] ^ m9[1] ^ me[2] ^ mb[3],
                               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return o;
  endfunction

  // Single shared round datapath.
  assign shifted = invShiftRows(st_q);
  assign subbed  = invSubBytes(shifted);
  assign keyed   = addRoundKey(subbed, rk_in);
  assign mixed   = invMixCollumns(keyed);

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign rk_idx    = rnd_q;
  assign out_data  = st_q;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRound) || (state_q == StFinal);

  // Next-state logic: load on accept (from IDLE or DONE), iterate rounds, finish, hand off.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          st_d    = addRoundKey(in_data, rk_in);
          rnd_d   = NrLast;
          state_d = StRound;
        end else if (state_q == StDone && out_ready) begin
          state_d = StIdle;
        end
      end
      StRound: begin
        st_d  = mixed;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          state_d = StFinal;
        end
      end
      StFinal: begin
        st_d    = keyed;
        rnd_d   = NrIdx;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rnd_q   <= NrIdx;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: three instances (NR = 10/12/14) fed from a bench-side key
// schedule. Expected plaintexts come from FIPS-197 vectors or a forward AES model and are
// queued when a block is driven, then popped when the block completes.
module tb_aes_inv_cipher_iter;

  logic clk;
  logic reset;
  logic [2:0]        in_valid;
  logic [2:0]        in_ready;
  logic [2:0][127:0] in_data;
  logic [2:0][3:0]   rk_idx;
  logic [2:0][127:0] rk_in;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [2:0][127:0] out_data;
  logic [2:0]        busy;

  logic [127:0] rks [3][16];
  logic [7:0]   sbox [256];
  logic [127:0] exp_q [$];
  int           nrs [3] = '{10, 12, 14};
  int           checks = 0;
  int           errors = 0;

  localparam logic [127:0] Pt   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] Ct14 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_inv_cipher_iter #(.NR(10)) u_dut10 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .rk_idx(rk_idx[0]), .rk_in(rk_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );
  aes_inv_cipher_iter #(.NR(12)) u_dut12 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .rk_idx(rk_idx[1]), .rk_in(rk_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );
  aes_inv_cipher_iter #(.NR(14)) u_dut14 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .rk_idx(rk_idx[2]), .rk_in(rk_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
  );

  // Zero-latency key-schedule read.
  assign rk_in[0] = rks[0][rk_idx[0]];
  assign rk_in[1] = rks[1][rk_idx[1]];
  assign rk_in[2] = rks[2][rk_idx[2]];

  // ---------------- forward AES reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256 && a != 0; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) begin
          inv = 8'(b);
          break;
        end
      end
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand(input int d, input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rks[d][r] = '0;
    for (int r = 0; r <= nr; r++) rks[d][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8 * i +: 8] = sbox[s[8 * i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
      o[127 - 32 * c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                               a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                               a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                               gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input int d, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rks[d][0];
    for (int r = 1; r < nrs[d]; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rks[d][r];
    return shift_rows(sub_bytes(s)) ^ rks[d][nrs[d]];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present ct, accept it, then follow the block cycle by cycle until DONE.
  task automatic feed(input int d, input logic [127:0] ct, input bit keep_valid,
                      input logic [127:0] nxt);
    int nr;
    nr = nrs[d];
    in_valid[d] = 1'b1;
    in_data[d]  = ct;
    chk("accept_in_ready", 128'(in_ready[d]), 128'd1);
    chk("accept_rk_idx", 128'(rk_idx[d]), 128'(nr));
    step();
    in_valid[d] = keep_valid;
    in_data[d]  = nxt;
    for (int n = 1; n <= nr + 1; n++) begin
      if (n > 1) step();
      chk("rk_idx", 128'(rk_idx[d]), (n <= nr) ? 128'(nr - n) : 128'(nr));
      chk("busy", 128'(busy[d]), 128'(n <= nr));
      chk("out_valid", 128'(out_valid[d]), 128'(n == nr + 1));
      if (n <= nr) chk("in_ready_busy", 128'(in_ready[d]), 128'd0);
    end
    chk("in_ready_done", 128'(in_ready[d]), 128'(out_ready[d]));
    chk("out_data", out_data[d], exp_q.pop_front());
  endtask

  task automatic drain(input int d);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    step();
    chk("idle_out_valid", 128'(out_valid[d]), 128'd0);
    chk("idle_in_ready", 128'(in_ready[d]), 128'd1);
    chk("idle_busy", 128'(busy[d]), 128'd0);
  endtask

  task automatic chk_reset_state(input int d);
    chk("rst_in_ready", 128'(in_ready[d]), 128'd1);
    chk("rst_out_valid", 128'(out_valid[d]), 128'd0);
    chk("rst_out_data", out_data[d], 128'd0);
    chk("rst_busy", 128'(busy[d]), 128'd0);
    chk("rst_rk_idx", 128'(rk_idx[d]), 128'(nrs[d]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, ct;
    logic [127:0] pts [4];
    logic [127:0] cts [4];

    build_sbox();
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);

    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    step();
    step();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) chk_reset_state(d);

    // FIPS-197 C.1 / C.2 / C.3 decryptions
    exp_q.push_back(Pt);
    feed(0, Ct10, 1'b0, rand128());
    drain(0);
    exp_q.push_back(Pt);
    feed(1, Ct12, 1'b0, rand128());
    drain(1);
    exp_q.push_back(Pt);
    feed(2, Ct14, 1'b0, rand128());
    drain(2);

    // Random blocks through the forward model for every key size
    for (int d = 0; d < 3; d++) begin
      pt = rand128();
      exp_q.push_back(pt);
      feed(d, encrypt(d, pt), 1'b0, rand128());
      drain(d);
    end

    // Backpressure: result must hold while out_ready is low
    out_ready[0] = 1'b0;
    pt = rand128();
    exp_q.push_back(pt);
    feed(0, encrypt(0, pt), 1'b0, rand128());
    for (int i = 0; i < 20; i++) begin
      in_valid[0] = i[0];
      in_data[0]  = rand128();
      step();
      chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
      chk("bp_out_data", out_data[0], pt);
      chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    drain(0);

    // Back-to-back: in_valid held, each DONE cycle accepts the next block
    for (int k = 0; k < 4; k++) begin
      pts[k] = rand128();
      cts[k] = encrypt(0, pts[k]);
      exp_q.push_back(pts[k]);
    end
    for (int k = 0; k < 4; k++) begin
      feed(0, cts[k], k < 3, (k < 3) ? cts[(k + 1) % 4] : rand128());
    end
    drain(0);

    // Reset in the middle of a block, at rnd = 5
    pt = rand128();
    ct = encrypt(0, pt);
    in_valid[0] = 1'b1;
    in_data[0]  = ct;
    step();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_rk_idx", 128'(rk_idx[0]), 128'd5);
    chk("mid_busy", 128'(busy[0]), 128'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_state(0);
    step();
    chk("post_rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("post_rst_busy", 128'(busy[0]), 128'd0);
    exp_q.push_back(pt);
    feed(0, ct, 1'b0, rand128());
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
